// File: rtl/cache_ctrl_refill.sv
// Response / miss-handling stage behind the cache pipeline: returns hit data,
// posts write-through requests and refills missed lines into a round-robin victim way.
module cache_ctrl_refill #(
  parameter int ADDR_WIDTH       = 32,
  parameter int CLINE_SIZE_WORD  = 4,
  parameter int CLINE_ADDR_WIDTH = 7,
  parameter int CLINE_WORD_WIDTH = 32,
  parameter int NUM_WAYS         = 4,
  parameter int WMASK_WIDTH      = 4
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    us_vld_i,
  output logic                                                    us_rdy_o,
  input  logic                                                    us_hit_i,
  input  logic                                                    us_we_i,
  input  logic [ADDR_WIDTH-1:0]                                   us_addr_i,
  input  logic [CLINE_WORD_WIDTH-1:0]                             us_ddat_i,
  input  logic [CLINE_WORD_WIDTH-1:0]                             us_wdat_i,
  input  logic [WMASK_WIDTH-1:0]                                  us_wmask_i,
  output logic                                                    rsp_vld_o,
  input  logic                                                    rsp_rdy_i,
  output logic [CLINE_WORD_WIDTH-1:0]                             rsp_dat_o,
  output logic                                                    mem_req_vld_o,
  input  logic                                                    mem_req_rdy_i,
  output logic                                                    mem_req_we_o,
  output logic                                                    mem_req_burst_o,
  output logic [ADDR_WIDTH-1:0]                                   mem_req_addr_o,
  output logic [CLINE_WORD_WIDTH-1:0]                             mem_req_wdat_o,
  output logic [WMASK_WIDTH-1:0]                                  mem_req_wmask_o,
  input  logic                                                    mem_rsp_vld_i,
  input  logic [CLINE_WORD_WIDTH-1:0]                             mem_rsp_dat_i,
  output logic [NUM_WAYS-1:0]                                     fill_we_o,
  output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0]     fill_addr_o,
  output logic [CLINE_WORD_WIDTH-1:0]                             fill_dat_o,
  output logic [NUM_WAYS-1:0]                                     fill_tag_we_o,
  output logic [CLINE_ADDR_WIDTH-1:0]                             fill_tag_addr_o,
  output logic [ADDR_WIDTH-CLINE_ADDR_WIDTH-$clog2(CLINE_SIZE_WORD):0] fill_tag_o,
  output logic                                                    phy_req_o
);

  localparam int CLINE_OFFSET = $clog2(CLINE_SIZE_WORD);
  localparam int CA_WIDTH     = CLINE_ADDR_WIDTH + CLINE_OFFSET;
  localparam int VIC_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LINE_WIDTH   = ADDR_WIDTH - CLINE_OFFSET;

  typedef enum logic [2:0] {S_IDLE, S_WT, S_RSP, S_MREQ, S_MFILL, S_MTAG} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic [CLINE_WORD_WIDTH-1:0]     r_wdat;
  logic [WMASK_WIDTH-1:0]          r_wmask;
  logic [CLINE_WORD_WIDTH-1:0]     r_rsp;
  logic [CLINE_OFFSET-1:0]         r_beat;
  logic                            r_burst;
  logic [VIC_WIDTH-1:0]            r_victim;
  logic [LINE_WIDTH-1:0]           r_lf_line;
  logic                            r_lf_vld;

  logic                            w_accept;
  logic                            w_dup;
  logic                            w_beat;
  logic                            w_last;
  logic                            w_crit;
  logic [NUM_WAYS-1:0]             w_victim_oh;

  assign w_accept    = us_vld_i && us_rdy_o;
  // A miss to the line most recently filled is served uncached so the line is never filled twice.
  assign w_dup       = r_lf_vld && (r_addr[ADDR_WIDTH-1:CLINE_OFFSET] == r_lf_line);
  assign w_beat      = (r_state == S_MFILL) && mem_rsp_vld_i;
  assign w_last      = r_burst ? (&r_beat) : 1'b1;
  assign w_crit      = !r_burst || (r_beat == r_addr[CLINE_OFFSET-1:0]);
  assign w_victim_oh = NUM_WAYS'(1) << r_victim;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = us_we_i ? S_WT : (us_hit_i ? S_RSP : S_MREQ);
      S_WT:    if (mem_req_rdy_i) w_next = S_RSP;
      S_MREQ:  if (mem_req_rdy_i) w_next = S_MFILL;
      S_MFILL: if (w_beat && w_last) w_next = r_burst ? S_MTAG : S_RSP;
      S_MTAG:  w_next = S_RSP;
      S_RSP:   if (rsp_rdy_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat    <= '0;
      r_burst   <= 1'b0;
      r_victim  <= '0;
      r_lf_line <= '0;
      r_lf_vld  <= 1'b0;
    end else begin
      if (r_state == S_MREQ && mem_req_rdy_i) begin
        r_beat  <= '0;
        r_burst <= !w_dup;
      end else if (w_beat) begin
        r_beat <= r_beat + 1'b1;
      end
      if (r_state == S_MTAG) begin
        r_lf_line <= r_addr[ADDR_WIDTH-1:CLINE_OFFSET];
        r_lf_vld  <= 1'b1;
        r_victim  <= (r_victim == VIC_WIDTH'(NUM_WAYS-1)) ? '0 : r_victim + 1'b1;
      end
    end
  end

  // Request and response payload registers; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= us_addr_i;
      r_wdat  <= us_wdat_i;
      r_wmask <= us_wmask_i;
    end
    if (w_accept && !us_we_i && us_hit_i) begin
      r_rsp <= us_ddat_i;
    end else if (r_state == S_WT && mem_req_rdy_i) begin
      r_rsp <= '0;
    end else if (w_beat && w_crit) begin
      r_rsp <= mem_rsp_dat_i;
    end
  end

  always_comb begin
    us_rdy_o        = 1'b0;
    rsp_vld_o       = 1'b0;
    rsp_dat_o       = '0;
    mem_req_vld_o   = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_burst_o = 1'b0;
    mem_req_addr_o  = '0;
    mem_req_wdat_o  = '0;
    mem_req_wmask_o = '0;
    fill_we_o       = '0;
    fill_addr_o     = '0;
    fill_dat_o      = '0;
    fill_tag_we_o   = '0;
    fill_tag_addr_o = '0;
    fill_tag_o      = '0;
    phy_req_o       = 1'b0;
    case (r_state)
      S_IDLE: us_rdy_o = reset;
      S_WT: begin
        mem_req_vld_o   = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = r_addr;
        mem_req_wdat_o  = r_wdat;
        mem_req_wmask_o = r_wmask;
      end
      S_MREQ: begin
        phy_req_o       = 1'b1;
        mem_req_vld_o   = 1'b1;
        mem_req_burst_o = !w_dup;
        mem_req_addr_o  = w_dup ? r_addr
                                : {r_addr[ADDR_WIDTH-1:CLINE_OFFSET], {CLINE_OFFSET{1'b0}}};
      end
      S_MFILL: begin
        phy_req_o = 1'b1;
        if (mem_rsp_vld_i && r_burst) begin
          fill_we_o   = w_victim_oh;
          fill_addr_o = {r_addr[CA_WIDTH-1:CLINE_OFFSET], r_beat};
          fill_dat_o  = mem_rsp_dat_i;
        end
      end
      S_MTAG: begin
        phy_req_o       = 1'b1;
        fill_tag_we_o   = w_victim_oh;
        fill_tag_addr_o = r_addr[CA_WIDTH-1:CLINE_OFFSET];
        fill_tag_o      = {1'b1, r_addr[ADDR_WIDTH-1:CA_WIDTH]};
      end
      S_RSP: begin
        rsp_vld_o = 1'b1;
        rsp_dat_o = r_rsp;
      end
      default: ;
    endcase
  end

endmodule
